// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, alternating under contention.
// Defining MEM_ARB_TIMEOUT_EN adds a response timeout that reports err and returns zero data.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          stall,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

    state_t state;
    logic   last_d;
    logic   sel_d;
    logic   arb_req;
    logic   timeout;
    logic   resp;

    // D wins a tie unless it won the previous grant, so neither side starves.
    assign sel_d   = d_req & (~if_req | ~last_d);
    assign arb_req = (state == IDLE) & (if_req | d_req);

    always_comb begin
        m_req   = arb_req;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        if (arb_req) begin
            if (sel_d) begin
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
            end else begin
                m_addr  = if_addr;
            end
        end
    end

    assign if_gnt = arb_req & ~sel_d & m_gnt;
    assign d_gnt  = arb_req &  sel_d & m_gnt;

    // A response only counts while a transaction is outstanding; stale m_rvalid in IDLE is dropped.
    assign resp      = m_rvalid | timeout;
    assign if_rvalid = (state == WAIT_IF) & resp;
    assign d_rvalid  = (state == WAIT_D)  & resp;
    assign if_rdata  = timeout ? '0 : m_rdata;
    assign d_rdata   = timeout ? '0 : m_rdata;

    assign stall = (if_req & ~if_rvalid) | (d_req & ~d_rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_gnt) begin
                        state  <= WAIT_IF;
                        last_d <= 1'b0;
                    end else if (d_gnt) begin
                        state  <= WAIT_D;
                        last_d <= 1'b1;
                    end
                end
                WAIT_IF, WAIT_D: begin
                    if (resp) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;

    // Counter idles at zero so it starts fresh on every WAIT entry; it fires on the TIMEOUT_CYC-th silent cycle.
    assign timeout = (state != IDLE) & ~m_rvalid & (wait_cnt == CW'(TIMEOUT_CYC - 1));
    assign err     = timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state == IDLE) || m_rvalid || timeout) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory model answers grants and a scoreboard checks response routing.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [3:0]    d_wstrb = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          stall, err;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_addr_q = '0;
    int          vectors = 0;
    int          miscompares = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return 32'h00A00093 ^ (a - 32'h100);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, then lets the combinational outputs settle.
    task automatic apply_stimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                                  input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dws,
                                  input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = dws;
        m_gnt = g; m_rvalid = rv; m_rdata = rd;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_m_req"}, m_req, 0);
        check_output({tag, "_m_addr"}, m_addr, 0);
        check_output({tag, "_gnt"}, {if_gnt, d_gnt}, 0);
        check_output({tag, "_rvalid"}, {if_rvalid, d_rvalid}, 0);
        check_output({tag, "_stall"}, stall, 0);
        check_output({tag, "_err"}, err, 0);
    endtask

    task automatic expect_grant(input bit is_d, input logic [31:0] a, input logic we,
                                input logic [31:0] wd, input logic [3:0] ws);
        exp_t e;
        check_output("grant_m_req", m_req, 1);
        check_output("grant_m_addr", m_addr, a);
        check_output("grant_m_we", m_we, we);
        check_output("grant_m_wdata", m_wdata, wd);
        check_output("grant_m_wstrb", m_wstrb, ws);
        check_output("grant_if_gnt", if_gnt, !is_d);
        check_output("grant_d_gnt", d_gnt, is_d);
        check_output("grant_rvalid", {if_rvalid, d_rvalid}, 0);
        e.is_d = is_d;
        e.data = mem_model(a);
        sb.push_back(e);
        mem_addr_q = a;
    endtask

    task automatic check_response();
        exp_t e;
        if (sb.size() == 0) begin
            check_output("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check_output("rsp_if_rvalid", if_rvalid, !e.is_d);
            check_output("rsp_d_rvalid", d_rvalid, e.is_d);
            check_output("rsp_rdata", e.is_d ? d_rdata : if_rdata, e.data);
            check_output("rsp_m_req", m_req, 0);
            check_output("rsp_err", err, 0);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch: grant at t0, response at t3
        apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
        expect_grant(0, 32'h100, 0, 0, 0);
        check_output("fetch_stall_t0", stall, 1);
        for (int i = 1; i < 3; i++) begin
            apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
            check_output("fetch_wait_m_req", m_req, 0);
            check_output("fetch_wait_gnt", if_gnt, 0);
            check_output("fetch_wait_rvalid", if_rvalid, 0);
            check_output("fetch_wait_stall", stall, 1);
        end
        apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, mem_model(mem_addr_q));
        check_response();
        check_output("fetch_rdata_spec", if_rdata, 32'h00A00093);
        check_output("fetch_stall_t3", stall, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_quiet("fetch_done");

        // Asynchronous reset mid-cycle while a fetch is outstanding
        apply_stimulus(1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0);
        expect_grant(0, 32'h104, 0, 0, 0);
        apply_stimulus(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        if_req = 1'b0;
        #1;
        check_quiet("async_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        check_quiet("late_rsp_after_rst");

        // Contention: D, IF, D, IF with both requests held
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1, 32'h180, 1, 1, 32'h200, 32'hDEADBEEF, 4'b1111, 1, 0, 0);
            if (k % 2 == 0) expect_grant(1, 32'h200, 1, 32'hDEADBEEF, 4'b1111);
            else            expect_grant(0, 32'h180, 0, 0, 0);
            apply_stimulus(1, 32'h180, 1, 1, 32'h200, 32'hDEADBEEF, 4'b1111, 0, 1, mem_model(mem_addr_q));
            check_response();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_quiet("contend_done");

        // Back-pressure: m_gnt low for 5 cycles, d_req arriving mid-wait takes over the selection
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 32'h300, (i >= 2), 0, 32'h340, 0, 0, 0, 0, 0);
            check_output("bp_m_req", m_req, 1);
            check_output("bp_m_addr", m_addr, (i >= 2) ? 32'h340 : 32'h300);
            check_output("bp_gnt", {if_gnt, d_gnt}, 0);
            check_output("bp_stall", stall, 1);
        end
        apply_stimulus(1, 32'h300, 1, 0, 32'h340, 0, 0, 1, 0, 0);
        expect_grant(1, 32'h340, 0, 0, 0);
        apply_stimulus(1, 32'h300, 1, 0, 32'h340, 0, 0, 0, 1, mem_model(mem_addr_q));
        check_response();
        apply_stimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
        expect_grant(0, 32'h300, 0, 0, 0);
        apply_stimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 1, mem_model(mem_addr_q));
        check_response();

        // Stale m_rvalid in IDLE, then m_gnt and m_rvalid together in IDLE
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00001234);
        check_quiet("stale_rvalid");
        apply_stimulus(1, 32'h400, 0, 0, 0, 0, 0, 1, 1, 32'h00005678);
        expect_grant(0, 32'h400, 0, 0, 0);
        apply_stimulus(1, 32'h400, 0, 0, 0, 0, 0, 0, 1, mem_model(mem_addr_q));
        check_response();

        // Reset pulse during WAIT_D drops the load; the next request is granted normally
        apply_stimulus(0, 0, 1, 0, 32'h500, 0, 0, 1, 0, 0);
        expect_grant(1, 32'h500, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 32'h500, 0, 0, 0, 0, 0);
        check_output("waitd_stall", stall, 1);
        #2;
        rst_n = 1'b0;
        m_rvalid = 1'b1;
        #1;
        check_output("rst_waitd_d_rvalid", d_rvalid, 0);
        check_output("rst_waitd_idle_m_req", m_req, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 1, 0, 32'h500, 0, 0, 1, 0, 0);
        expect_grant(1, 32'h500, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 32'h500, 0, 0, 0, 1, mem_model(mem_addr_q));
        check_response();

        // No response after a data grant: timeout on cycle 8 if enabled, otherwise WAIT_D holds
        reset_pulse();
        apply_stimulus(0, 0, 1, 0, 32'h600, 0, 0, 1, 0, 0);
        expect_grant(1, 32'h600, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            apply_stimulus(0, 0, 1, 0, 32'h600, 0, 0, 0, 0, 32'h55555555);
`ifdef MEM_ARB_TIMEOUT_EN
            check_output("tmo_err", err, (i == 8));
            check_output("tmo_d_rvalid", d_rvalid, (i == 8));
            check_output("tmo_m_req", m_req, (i > 8));
            check_output("tmo_stall", stall, (i != 8));
            if (i == 8) check_output("tmo_rdata", d_rdata, 32'h0);
`else
            check_output("hold_err", err, 0);
            check_output("hold_d_rvalid", d_rvalid, 0);
            check_output("hold_m_req", m_req, 0);
            check_output("hold_stall", stall, 1);
`endif
        end
        reset_pulse();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
